// File: rtl/bus_responder_pkg.sv
// Shared constants for bus_responder: register offsets, control/status bit
// positions and the timer state encoding.
package bus_responder_pkg;

   localparam logic [7:0] OFF_GPIO_OUT  = 8'd0;
   localparam logic [7:0] OFF_GPIO_IN   = 8'd1;
   localparam logic [7:0] OFF_TMR_CTRL  = 8'd2;
   localparam logic [7:0] OFF_TMR_PRESC = 8'd3;
   localparam logic [7:0] OFF_TMR_CMP   = 8'd4;
   localparam logic [7:0] OFF_TMR_CNT   = 8'd5;
   localparam logic [7:0] OFF_TMR_STAT  = 8'd6;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int STAT_MATCH   = 0;

   typedef enum logic [1:0] {
      TMR_IDLE = 2'd0,
      TMR_RUN  = 2'd1,
      TMR_DONE = 2'd2
   } tmr_state_t;

endpackage

// File: rtl/bus_timer.sv
// Prescaled compare timer with oneshot mode and a sticky, write-1-to-clear
// MATCH flag. Instantiated by bus_responder when BUS_RESPONDER_TIMER_EN is defined.
module bus_timer
   import bus_responder_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wdata,
   input  logic       ctrl_we,
   input  logic       presc_we,
   input  logic       cmp_we,
   input  logic       stat_we,
   output logic [7:0] ctrl,
   output logic [7:0] presc,
   output logic [7:0] cmp,
   output logic [7:0] cnt,
   output logic [7:0] stat,
   output logic       irq
);

   tmr_state_t state, state_next;
   logic [7:0] pcnt;
   logic       match;
   logic       tick, hit;
   logic       enter_done, stop;

   assign tick = (state == TMR_RUN) && (pcnt == presc);
   assign hit  = tick && (cnt == cmp);

   always_ff @(posedge clk) begin
      if (reset) state <= TMR_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         TMR_IDLE: if (ctrl_we && wdata[CTRL_EN]) state_next = TMR_RUN;
         TMR_RUN: begin
            if (ctrl_we && !wdata[CTRL_EN])     state_next = TMR_IDLE;
            else if (hit && ctrl[CTRL_ONESHOT]) state_next = TMR_DONE;
         end
         TMR_DONE: if (ctrl_we && wdata[CTRL_EN]) state_next = TMR_RUN;
         default:  state_next = TMR_IDLE;
      endcase
   end

   always_comb begin
      enter_done = (state == TMR_RUN) && (state_next == TMR_DONE);
      stop       = (state == TMR_RUN) && (state_next == TMR_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl  <= 8'h00;
         presc <= 8'h00;
         cmp   <= 8'h00;
         cnt   <= 8'h00;
         pcnt  <= 8'h00;
         match <= 1'b0;
      end else begin
         if (ctrl_we)    ctrl <= wdata;
         // hardware EN clear takes priority over a simultaneous CTRL write
         if (enter_done) ctrl[CTRL_EN] <= 1'b0;
         if (presc_we)   presc <= wdata;
         if (cmp_we)     cmp <= wdata;
         if (stop) begin
            cnt  <= 8'h00;
            pcnt <= 8'h00;
         end else if (state == TMR_RUN) begin
            if (tick) begin
               pcnt <= 8'h00;
               cnt  <= hit ? 8'h00 : cnt + 8'd1;
            end else begin
               pcnt <= pcnt + 8'd1;
            end
         end
         if (hit)                                match <= 1'b1;
         else if (stat_we && wdata[STAT_MATCH]) match <= 1'b0;
      end
   end

   assign stat = {7'b0, match};
   assign irq  = match;

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped bus slave: RAM below MMIO_BASE, GPIO and optional timer registers
// above it. Define BUS_RESPONDER_TIMER_EN to include the timer.
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter logic [7:0] MMIO_BASE   = 8'hF0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       W_R,
   input  logic [7:0] i_Address_Data_Bus,
   input  logic [7:0] i_DataOut_Bus,
   output logic [7:0] o_DataIn_Bus,
   input  logic [7:0] i_gpio_in,
   output logic [7:0] o_gpio_out,
   output logic       o_timer_irq
);

   logic [7:0] ram [0:int'(MMIO_BASE)-1];
   logic [7:0] sync [SYNC_STAGES];
   logic [7:0] gpio_out;
   logic       is_mmio;
   logic       wr_mmio;
   logic [7:0] offset;
   logic [7:0] reg_rdata;
   logic [7:0] rdata;

   assign is_mmio = (i_Address_Data_Bus >= MMIO_BASE);
   assign offset  = i_Address_Data_Bus - MMIO_BASE;
   assign wr_mmio = W_R && is_mmio;

`ifdef BUS_RESPONDER_TIMER_EN
   logic [7:0] tmr_ctrl, tmr_presc, tmr_cmp, tmr_cnt, tmr_stat;
   logic       tmr_irq;

   bus_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .wdata    (i_DataOut_Bus),
      .ctrl_we  (wr_mmio && (offset == OFF_TMR_CTRL)),
      .presc_we (wr_mmio && (offset == OFF_TMR_PRESC)),
      .cmp_we   (wr_mmio && (offset == OFF_TMR_CMP)),
      .stat_we  (wr_mmio && (offset == OFF_TMR_STAT)),
      .ctrl     (tmr_ctrl),
      .presc    (tmr_presc),
      .cmp      (tmr_cmp),
      .cnt      (tmr_cnt),
      .stat     (tmr_stat),
      .irq      (tmr_irq)
   );

   assign o_timer_irq = tmr_irq;
`else
   assign o_timer_irq = 1'b0;
`endif

   // RAM keeps its contents across reset
   always_ff @(posedge clk) begin
      if (W_R && !is_mmio) ram[i_Address_Data_Bus] <= i_DataOut_Bus;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= 8'h00;
      end else begin
         sync[0] <= i_gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end

   always_comb begin
      reg_rdata = 8'h00;
      case (offset)
         OFF_GPIO_OUT:  reg_rdata = gpio_out;
         OFF_GPIO_IN:   reg_rdata = sync[SYNC_STAGES-1];
`ifdef BUS_RESPONDER_TIMER_EN
         OFF_TMR_CTRL:  reg_rdata = tmr_ctrl;
         OFF_TMR_PRESC: reg_rdata = tmr_presc;
         OFF_TMR_CMP:   reg_rdata = tmr_cmp;
         OFF_TMR_CNT:   reg_rdata = tmr_cnt;
         OFF_TMR_STAT:  reg_rdata = tmr_stat;
`endif
         default:       reg_rdata = 8'h00;
      endcase
   end

   always_comb begin
      rdata = reg_rdata;
      if (!is_mmio) rdata = ram[i_Address_Data_Bus];
   end

   // read data always reflects pre-write contents of the sampled address
   always_ff @(posedge clk) begin
      if (reset) begin
         o_DataIn_Bus <= 8'h00;
         gpio_out     <= 8'h00;
      end else begin
         o_DataIn_Bus <= rdata;
         if (wr_mmio && (offset == OFF_GPIO_OUT)) gpio_out <= i_DataOut_Bus;
      end
   end

   assign o_gpio_out = gpio_out;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder; covers the timer when BUS_RESPONDER_TIMER_EN
// is defined and checks the timer-less register window otherwise.
module tb_bus_responder;

   localparam logic [7:0] BASE = 8'hF0;
   localparam int         SYNC = 2;
`ifdef BUS_RESPONDER_TIMER_EN
   localparam bit HAS_TMR = 1'b1;
`else
   localparam bit HAS_TMR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       W_R = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdat = 8'h00;
   logic [7:0] gin = 8'h00;
   logic [7:0] rdat;
   logic [7:0] gout;
   logic       irq;

   always #5 clk = ~clk;

   bus_responder #(.MMIO_BASE(BASE), .SYNC_STAGES(SYNC)) dut (
      .clk                (clk),
      .reset              (reset),
      .W_R                (W_R),
      .i_Address_Data_Bus (addr),
      .i_DataOut_Bus      (wdat),
      .o_DataIn_Bus       (rdat),
      .i_gpio_in          (gin),
      .o_gpio_out         (gout),
      .o_timer_irq        (irq)
   );

   typedef struct packed {
      logic [7:0] rdata;
      logic [7:0] gpio;
      logic       irq;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: plain register/RAM image plus a running flag for the timer
   logic [7:0] m_ram [256];
   logic [7:0] m_gpio, m_ctrl, m_presc, m_cmp, m_cnt, m_pre;
   logic       m_match, m_run;
   logic [7:0] gq[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a, input logic [7:0] gs);
      logic [7:0] off;
      off = a - BASE;
      if (a < BASE) return m_ram[a];
      case (off)
         8'd0: return m_gpio;
         8'd1: return gs;
         8'd2: return HAS_TMR ? m_ctrl : 8'h00;
         8'd3: return HAS_TMR ? m_presc : 8'h00;
         8'd4: return HAS_TMR ? m_cmp : 8'h00;
         8'd5: return HAS_TMR ? m_cnt : 8'h00;
         8'd6: return HAS_TMR ? {7'b0, m_match} : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   function automatic void model_step(input logic rst, input logic wr, input logic [7:0] a,
                                      input logic [7:0] d, input logic [7:0] g);
      exp_t e;
      logic [7:0] gs, off;
      logic mm, tick, hit, ctrl_w, stop, start, shot;
      off = a - BASE;
      mm  = (a >= BASE);
      if (rst) begin
         m_gpio = 0; m_ctrl = 0; m_presc = 0; m_cmp = 0; m_cnt = 0; m_pre = 0;
         m_match = 0; m_run = 0;
         gq.delete();
         for (int i = 0; i < SYNC; i++) gq.push_back(8'h00);
         e = '0;
      end else begin
         gs = gq.pop_front();
         gq.push_back(g);
         e.rdata = m_read(a, gs);
         if (wr && !mm) m_ram[a] = d;
         if (wr && mm && off == 8'd0) m_gpio = d;
         if (HAS_TMR) begin
            tick   = m_run && (m_pre == m_presc);
            hit    = tick && (m_cnt == m_cmp);
            ctrl_w = wr && mm && off == 8'd2;
            stop   = m_run && ctrl_w && !d[0];
            start  = !m_run && ctrl_w && d[0];
            shot   = hit && m_ctrl[1] && !stop;
            if (m_run) begin
               if (tick) begin
                  m_pre = 0;
                  m_cnt = hit ? 8'h00 : 8'(m_cnt + 8'd1);
               end else begin
                  m_pre = 8'(m_pre + 8'd1);
               end
            end
            if (ctrl_w) m_ctrl = d;
            if (wr && mm && off == 8'd3) m_presc = d;
            if (wr && mm && off == 8'd4) m_cmp = d;
            if (hit) m_match = 1'b1;
            else if (wr && mm && off == 8'd6 && d[0]) m_match = 1'b0;
            if (stop) begin m_run = 0; m_cnt = 0; m_pre = 0; end
            if (shot) begin m_run = 0; m_ctrl[0] = 1'b0; end
            if (start) m_run = 1'b1;
         end
         e.gpio = m_gpio;
         e.irq  = m_match;
      end
      sb.push_back(e);
   endfunction

   task automatic cycle(input logic rst, input logic wr, input logic [7:0] a, input logic [7:0] d);
      reset = rst; W_R = wr; addr = a; wdat = d;
      @(posedge clk);
      model_step(rst, wr, a, d, gin);
      @(negedge clk);
   endtask

   // monitor: outputs are valid every cycle, so compare whenever an expectation is pending
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata", rdat, e.rdata);
            chk("gpio_out", gout, e.gpio);
            chk("irq", {7'b0, irq}, {7'b0, e.irq});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [7:0] ram_addrs [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hEF};

   initial begin
      logic [7:0] a, d, off;
      logic       wr, rst;
      int         r;

      repeat (3) cycle(1'b1, 1'b0, 8'h00, 8'h00);
      chk("reset_rdata", rdat, 8'h00);
      chk("reset_gpio", gout, 8'h00);
      chk("reset_irq", {7'b0, irq}, 8'h00);

      foreach (ram_addrs[i]) cycle(1'b0, 1'b1, ram_addrs[i], 8'($urandom));

      // RAM write/read and read-before-write
      cycle(1'b0, 1'b1, 8'h10, 8'hA5);
      cycle(1'b0, 1'b0, 8'h10, 8'h00);
      chk("ram_read", rdat, 8'hA5);
      cycle(1'b0, 1'b1, 8'h10, 8'h11);
      chk("read_before_write", rdat, 8'hA5);

      // GPIO out and synchronized GPIO in
      cycle(1'b0, 1'b1, BASE, 8'h3C);
      chk("gpio_write", gout, 8'h3C);
      gin = 8'h81;
      repeat (SYNC + 1) cycle(1'b0, 1'b0, BASE + 8'd1, 8'h00);
      chk("gpio_in_sync", rdat, 8'h81);

`ifdef BUS_RESPONDER_TIMER_EN
      // periodic timer: PRESC=1, CMP=3 -> MATCH 8 cycles after enable
      cycle(1'b0, 1'b1, BASE + 8'd3, 8'h01);
      cycle(1'b0, 1'b1, BASE + 8'd4, 8'h03);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 1'b0, BASE + 8'd5, 8'h00);
         chk($sformatf("periodic_irq_c%0d", i), {7'b0, irq}, (i == 8) ? 8'h01 : 8'h00);
      end
      cycle(1'b0, 1'b0, BASE + 8'd5, 8'h00);
      chk("cnt_after_match", rdat, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd6, 8'h01);
      chk("w1c_clear", {7'b0, irq}, 8'h00);

      // oneshot with CMP=0, PRESC=0
      cycle(1'b0, 1'b1, BASE + 8'd3, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd4, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h03);
      cycle(1'b0, 1'b0, BASE + 8'd6, 8'h00);
      chk("oneshot_irq", {7'b0, irq}, 8'h01);
      cycle(1'b0, 1'b0, BASE + 8'd2, 8'h00);
      chk("oneshot_ctrl", rdat, 8'h02);
      repeat (3) cycle(1'b0, 1'b0, BASE + 8'd5, 8'h00);
      chk("oneshot_cnt", rdat, 8'h00);

      // set wins over simultaneous W1C
      cycle(1'b0, 1'b1, BASE + 8'd6, 8'h01);
      chk("done_w1c", {7'b0, irq}, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h01);
      cycle(1'b0, 1'b1, BASE + 8'd6, 8'h01);
      chk("set_wins", {7'b0, irq}, 8'h01);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h00);
      cycle(1'b0, 1'b1, BASE + 8'd6, 8'h01);
      chk("later_w1c", {7'b0, irq}, 8'h00);
`else
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h01);
      cycle(1'b0, 1'b1, BASE + 8'd4, 8'h07);
      cycle(1'b0, 1'b0, BASE + 8'd4, 8'h00);
      chk("no_timer_cmp", rdat, 8'h00);
`endif

      // reset mid-run keeps RAM
      cycle(1'b0, 1'b1, 8'h10, 8'h5A);
      cycle(1'b0, 1'b1, BASE + 8'd3, 8'h02);
      cycle(1'b0, 1'b1, BASE + 8'd4, 8'h05);
      cycle(1'b0, 1'b1, BASE + 8'd2, 8'h01);
      repeat (4) cycle(1'b0, 1'b0, BASE + 8'd5, 8'h00);
      repeat (2) cycle(1'b1, 1'b0, 8'h00, 8'h00);
      chk("rst_gpio", gout, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
      chk("rst_rdata", rdat, 8'h00);
      cycle(1'b0, 1'b0, 8'h10, 8'h00);
      chk("ram_survives_reset", rdat, 8'h5A);
      cycle(1'b0, 1'b0, BASE + 8'd2, 8'h00);
      chk("ctrl_after_reset", rdat, 8'h00);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         r   = int'($urandom_range(0, 99));
         rst = (r == 99);
         wr  = 1'($urandom);
         if (r < 35) a = ram_addrs[$urandom_range(0, 9)];
         else        a = BASE + 8'($urandom_range(0, 9));
         off = a - BASE;
         if (a >= BASE && off == 8'd2)      d = 8'($urandom_range(0, 3));
         else if (a >= BASE && off == 8'd3) d = 8'($urandom_range(0, 3));
         else if (a >= BASE && off == 8'd4) d = 8'($urandom_range(0, 5));
         else                               d = 8'($urandom);
         if ($urandom_range(0, 9) == 0) gin = 8'($urandom);
         cycle(rst, wr, a, d);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 8'(sb.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter MMIO_BASE, default 8'hF0: first address of the register window; addresses below it map to RAM.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on i_gpio_in.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 W_R  in  1  bus direction from processor: 1 = write, 0 = read.
REQ-006 i_Address_Data_Bus  in  8  data address from processor.
REQ-007 i_DataOut_Bus  in  8  write data from processor.
REQ-008 o_DataIn_Bus  out  8  read data to processor.
REQ-009 i_gpio_in  in  8  asynchronous external inputs.
REQ-010 o_gpio_out  out  8  registered GPIO outputs.
REQ-011 o_timer_irq  out  1  level, equals TMR_STAT[0].

Function
REQ-012 Address < MMIO_BASE SHALL access a RAM of MMIO_BASE bytes; address >= MMIO_BASE SHALL access the register window at offset addr-MMIO_BASE.
REQ-013 Write: when W_R=1 at a rising edge, the addressed byte/register SHALL take i_DataOut_Bus at that edge.
REQ-014 Read: o_DataIn_Bus SHALL be registered and show the contents of the address sampled at the previous edge; latency is 1 cycle.
REQ-015 A write cycle SHALL also register read data; that data is the pre-write contents of the address (read-before-write).
REQ-016 Register map (offsets): 0 GPIO_OUT rw; 1 GPIO_IN ro (synchronized); 2 TMR_CTRL rw, bit0 EN, bit1 ONESHOT; 3 TMR_PRESC rw; 4 TMR_CMP rw; 5 TMR_CNT ro; 6 TMR_STAT, bit0 MATCH, write-1-to-clear; 7..end read 8'h00, writes ignored.
REQ-017 Writes to read-only registers SHALL be ignored.
REQ-018 Timer FSM states IDLE, RUN, DONE; IDLE->RUN when EN written 1; RUN->IDLE when EN written 0; RUN->DONE on match with ONESHOT=1; DONE->RUN when EN written 1 again.
REQ-019 In RUN, a prescaler SHALL count 0..TMR_PRESC and issue one tick per TMR_PRESC+1 cycles; TMR_CNT SHALL increment once per tick.
REQ-020 On a tick with TMR_CNT==TMR_CMP: TMR_CNT SHALL go to 0 and MATCH SHALL be set; with TMR_CMP=0, every tick matches.
REQ-021 On entering DONE, hardware SHALL clear TMR_CTRL.EN; TMR_CNT holds 0.
REQ-022 Leaving RUN for IDLE SHALL clear TMR_CNT and the prescaler.
REQ-023 A hardware MATCH set and a W1C in the same cycle SHALL leave MATCH=1 (set wins).
REQ-024 A write to TMR_PRESC or TMR_CMP in RUN SHALL take effect from the next cycle without restarting the count.
REQ-025 All 8-bit counters SHALL wrap modulo 256; there are no other overflow side effects.

Reset
REQ-026 On reset: o_DataIn_Bus=0, o_gpio_out=0, o_timer_irq=0, all registers 0, synchronizer flops 0, FSM=IDLE.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 Reset during a timer run SHALL abort it immediately and return to IDLE.

Configuration
REQ-029 Macro BUS_RESPONDER_TIMER_EN: when defined, the timer is present as specified; when undefined, offsets 2..6 read 8'h00, writes are ignored, o_timer_irq is tied 0, and no timer logic is synthesized.

Structure
REQ-030 A shared package SHALL hold the register-offset constants, the TMR_CTRL/TMR_STAT bit indices, and the timer-state enum.
REQ-031 The timer SHALL be a sub-module bus_timer, instantiated only under BUS_RESPONDER_TIMER_EN; RAM and decode stay in the top module.

Verification
REQ-032 Write 8'hA5 to 0x10, then read 0x10 -> o_DataIn_Bus=8'hA5 one cycle after the read address.
REQ-033 Write 8'h3C to 0xF0 -> o_gpio_out=8'h3C after that edge; drive i_gpio_in=8'h81, read 0xF1 -> 8'h81 by SYNC_STAGES+1 cycles.
REQ-034 PRESC=1, CMP=3, CTRL=8'h01 -> MATCH/o_timer_irq rises 8 cycles after enable; CNT sequence 0,1,2,3,0.
REQ-035 CTRL=8'h03 (oneshot), CMP=0, PRESC=0 -> MATCH after 1 tick; CTRL reads 8'h02; FSM=DONE; CNT stays 0.
REQ-036 Write 8'h01 to 0xF6 in the same cycle as a hardware match -> MATCH stays 1; a later W1C clears it.
REQ-037 Assert reset mid-run with RAM[0x10]=8'h5A -> all outputs 0 and FSM=IDLE; a read of 0x10 still returns 8'h5A; with the macro undefined, a read of 0xF2 returns 8'h00.
